// File: rtl/cdc_line_echo.sv
// Line-buffered echo endpoint for the USB CDC core: collects OUT bytes (uppercased)
// until an end-of-line byte or a full buffer, then streams the line back on IN.
module cdc_line_echo #(
  parameter int         BUF_DEPTH = 32,
  parameter logic [7:0] EOL_CHAR  = 8'h0D,
  parameter bit         APPEND_LF = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       busy_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_RX,
    ST_TX_DATA,
    ST_TX_CR,
    ST_TX_LF
  } state_t;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  state_t          state, state_d;
  logic [CW-1:0]   count, count_d, count_inc;
  logic [PW-1:0]   rd_ptr, rd_ptr_d, rd_addr;
  logic            eol, eol_d;
  logic            in_valid_d;
  logic [7:0]      in_data_d;
  logic            wr_en, rd_load;
  logic            rx_fire, tx_fire, last_byte;

  logic [7:0] mem [BUF_DEPTH];

  assign out_ready_o = (state == ST_RX) && !rst_i;
  assign busy_o      = (state != ST_RX);
  assign rx_fire     = out_valid_i && out_ready_o;
  assign tx_fire     = in_valid_o && in_ready_i;
  assign count_inc   = count + CW'(1);
  // TX_DATA is only entered with at least one stored byte, so count-1 never underflows.
  assign last_byte   = ({1'b0, rd_ptr} == (count - CW'(1)));

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state;
    count_d    = count;
    rd_ptr_d   = rd_ptr;
    eol_d      = eol;
    in_valid_d = in_valid_o;
    in_data_d  = in_data_o;
    wr_en      = 1'b0;
    rd_load    = 1'b0;
    rd_addr    = rd_ptr;

    case (state)
      ST_RX: begin
        if (rx_fire) begin
          if (out_data_i == EOL_CHAR) begin
            eol_d   = 1'b1;
            state_d = (count == '0) ? ST_TX_CR : ST_TX_DATA;
          end else begin
            wr_en   = 1'b1;
            count_d = count_inc;
            if (count_inc == FULL) begin
              eol_d   = 1'b0;
              state_d = ST_TX_DATA;
            end
          end
        end
      end

      ST_TX_DATA: begin
        if (!in_valid_o) begin
          // Bubble cycle: the registered buffer read fills the output register.
          rd_load    = 1'b1;
          in_valid_d = 1'b1;
        end else if (tx_fire) begin
          if (last_byte) begin
            rd_ptr_d = '0;
            count_d  = '0;
            if (eol) begin
              state_d   = ST_TX_CR;
              in_data_d = 8'h0D;
            end else begin
              state_d    = ST_RX;
              in_valid_d = 1'b0;
            end
          end else begin
            // Fetch the next byte at the transfer edge to keep the stream gap-free.
            rd_ptr_d = rd_ptr + PW'(1);
            rd_addr  = rd_ptr + PW'(1);
            rd_load  = 1'b1;
          end
        end
      end

      ST_TX_CR: begin
        if (!in_valid_o) begin
          in_valid_d = 1'b1;
          in_data_d  = 8'h0D;
        end else if (tx_fire) begin
          if (APPEND_LF) begin
            state_d   = ST_TX_LF;
            in_data_d = 8'h0A;
          end else begin
            state_d    = ST_RX;
            in_valid_d = 1'b0;
          end
        end
      end

      ST_TX_LF: begin
        if (tx_fire) begin
          state_d    = ST_RX;
          in_valid_d = 1'b0;
        end
      end

      default: state_d = ST_RX;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_RX;
      count      <= '0;
      rd_ptr     <= '0;
      eol        <= 1'b0;
      in_valid_o <= 1'b0;
      in_data_o  <= 8'h00;
    end else begin
      state      <= state_d;
      count      <= count_d;
      rd_ptr     <= rd_ptr_d;
      eol        <= eol_d;
      in_valid_o <= in_valid_d;
      in_data_o  <= rd_load ? mem[rd_addr] : in_data_d;
    end
  end

  // NOTE: the line buffer is not reset; count gates what is ever read, and a
  // reset-free array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[count[PW-1:0]] <= to_upper(out_data_i);
  end

endmodule

// File: tb/tb_cdc_line_echo.sv
// Scoreboard bench for cdc_line_echo: stimulus pushes expected IN bytes, negedge
// monitors pop and compare on each IN transfer. A second instance runs with APPEND_LF=0.
module tb_cdc_line_echo;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] out_data_i;
  logic       out_valid_i;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b1;
  logic       busy_o;

  logic [7:0] out_data2;
  logic       out_valid2;
  logic       out_ready2;
  logic [7:0] in_data2;
  logic       in_valid2;
  logic       in_ready2 = 1'b1;
  logic       busy2;

  always #5 clk = ~clk;

  cdc_line_echo #(.BUF_DEPTH(32), .EOL_CHAR(8'h0D), .APPEND_LF(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .busy_o(busy_o)
  );

  cdc_line_echo #(.BUF_DEPTH(32), .EOL_CHAR(8'h0D), .APPEND_LF(1'b0)) dut_nolf (
    .clk_i(clk), .rst_i(rst_i),
    .out_data_i(out_data2), .out_valid_i(out_valid2), .out_ready_o(out_ready2),
    .in_data_o(in_data2), .in_valid_o(in_valid2), .in_ready_i(in_ready2),
    .busy_o(busy2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // in_ready_i driver: 0 = always ready, 1 = repeating stall pattern, 2 = never ready
  int   ready_mode = 0;
  int   pat_idx = 0;
  logic pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: in_ready_i = 1'b1;
      1: begin
        in_ready_i = pat[pat_idx];
        pat_idx = (pat_idx == 5) ? 0 : pat_idx + 1;
      end
      default: in_ready_i = 1'b0;
    endcase
  end

  // Monitor for the main instance: a transfer happens at the next posedge.
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (hold_pending) begin
      check("in_hold_valid", in_valid_o, 1);
      check("in_hold_data", in_data_o, hold_data);
    end
    hold_pending = in_valid_o && !in_ready_i && !rst_i;
    hold_data    = in_data_o;
    if (busy_o) check("busy_blocks_out_ready", out_ready_o, 0);
    if (in_valid_o && in_ready_i && !rst_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_unexpected: got 0x%0h, expected no byte at %0t", in_data_o, $time);
      end else begin
        exp_b = exp_q.pop_front();
        check("in_byte", in_data_o, exp_b);
      end
    end
  end

  logic [7:0] exp_b2;
  always @(negedge clk) begin
    if (in_valid2 && in_ready2 && !rst_i) begin
      if (exp_q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL nolf_unexpected: got 0x%0h, expected no byte at %0t", in_data2, $time);
      end else begin
        exp_b2 = exp_q2.pop_front();
        check("nolf_in_byte", in_data2, exp_b2);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    out_data_i  = b;
    out_valid_i = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_ready_o) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got out_ready_o=0, expected 1 for byte 0x%0h", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [7:0] b);
    check("nolf_out_ready", out_ready2, 1);
    out_data2  = b;
    out_valid2 = 1'b1;
    @(posedge clk);
    #1;
    out_valid2 = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_q2.size() == 0 && !busy_o && !busy2 && !in_valid2)
        done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size() + exp_q2.size());
    end
    check("idle_in_valid", in_valid_o, 0);
    check("idle_out_ready", out_ready_o, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_i = 1'b1;
    out_valid_i = 1'b0;
    out_data_i = 8'h00;
    out_valid2 = 1'b0;
    out_data2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_valid", in_valid_o, 0);
    check("rst_in_data", in_data_o, 8'h00);
    check("rst_busy", busy_o, 0);
    check("rst_out_ready_low", out_ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_out_ready", out_ready_o, 1);
    @(posedge clk);
    #1;

    // "ab" CR with out_valid_i held high across the line
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h61); send(8'h62); send(8'h0D);
    out_valid_i = 1'b0;
    check("eol_busy", busy_o, 1);
    check("eol_bubble", in_valid_o, 0);
    @(posedge clk);
    #1;
    check("first_valid", in_valid_o, 1);
    check("first_data", in_data_o, 8'h41);
    drain();

    // lone CR
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h0D);
    out_valid_i = 1'b0;
    check("empty_busy", busy_o, 1);
    check("empty_bubble", in_valid_o, 0);
    @(posedge clk);
    #1;
    check("empty_cr_valid", in_valid_o, 1);
    check("empty_cr_data", in_data_o, 8'h0D);
    drain();

    // APPEND_LF=0 instance: lone CR, then "ab" CR
    exp_q2.push_back(8'h0D);
    send2(8'h0D);
    drain();
    exp_q2.push_back(8'h41); exp_q2.push_back(8'h42); exp_q2.push_back(8'h0D);
    send2(8'h61); send2(8'h62); send2(8'h0D);
    drain();

    // full buffer without EOL
    for (int i = 0; i < 32; i++) exp_q.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 32; i++) send(8'h30 + 8'(i));
    out_valid_i = 1'b0;
    check("full_busy", busy_o, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (in_valid_o) seen = 1'b1;
    end
    check("full_stream_start", seen, 1);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      check("full_no_bubble", in_valid_o, 1);
    end
    @(negedge clk);
    check("full_no_crlf", in_valid_o, 0);
    check("full_out_ready", out_ready_o, 1);
    drain();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h7A); send(8'h0D);
    out_valid_i = 1'b0;
    drain();

    // "q1" CR under IN back-pressure
    ready_mode = 1;
    exp_q.push_back(8'h51); exp_q.push_back(8'h31);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h71); send(8'h31); send(8'h0D);
    out_valid_i = 1'b0;
    drain();
    ready_mode = 0;
    @(posedge clk);
    #1;

    // reset in the middle of an 8-byte line
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h41 + 8'(i));
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    for (int i = 0; i < 8; i++) send(8'h61 + 8'(i));
    send(8'h0D);
    out_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (in_valid_o) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    check("mid_line_busy", busy_o, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    check("midrst_in_valid", in_valid_o, 0);
    check("midrst_busy", busy_o, 0);
    @(negedge clk);
    check("midrst_out_ready", out_ready_o, 1);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h58); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h78); send(8'h0D);
    out_valid_i = 1'b0;
    drain();

    // byte offered while busy waits for RX and leads the next line
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h43); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h61); send(8'h62); send(8'h0D);
    out_data_i  = 8'h63;
    out_valid_i = 1'b1;
    check("hold_busy", busy_o, 1);
    check("hold_not_ready", out_ready_o, 0);
    send(8'h63);
    send(8'h0D);
    out_valid_i = 1'b0;
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
